ifmap_read_ctrl: RTL and testbench

IFMAP_READ_CTRL -- requirements
Module: ifmap_read_ctrl

---
 rtl/ifmap_read_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ifmap_read_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_read_ctrl.sv
// Read-side controller for the ifmap double buffer: walks the fx/fy/ox/oy
// convolution window for each bank and hands the bank back via a switch handshake.
module ifmap_read_ctrl #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              config_en,
  input  logic [CNT_W-1:0]  cfg_in_w,
  input  logic [CNT_W-1:0]  cfg_ox,
  input  logic [CNT_W-1:0]  cfg_oy,
  input  logic [CNT_W-1:0]  cfg_fx,
  input  logic [CNT_W-1:0]  cfg_fy,
  input  logic [CNT_W-1:0]  cfg_num_banks,
  input  logic [1:0]        cfg_stride,
  output logic              config_done,
  output logic              ready_to_switch,
  input  logic              switch,
  output logic              ren,
  input  logic              rready,
  output logic [ADDR_W-1:0] raddr,
  output logic              last_read,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WAIT_SWITCH, READ, DONE} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] in_w_q, in_w_d, ox_b_q, ox_b_d, oy_b_q, oy_b_d;
  logic [CNT_W-1:0] fx_b_q, fx_b_d, fy_b_q, fy_b_d, banks_q, banks_d;
  logic [1:0]       stride_q, stride_d;
  logic [CNT_W-1:0] fx_q, fx_d, fy_q, fy_d, ox_q, ox_d, oy_q, oy_d;
  logic [CNT_W-1:0] bank_q, bank_d, bank_inc;
  logic             config_done_q, config_done_d;
  logic             fx_last, fy_last, ox_last, oy_last, all_last;

  // A zero bound would make the window empty; it is read as a single step.
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    nz = (v == {CNT_W{1'b0}}) ? CNT_W'(1) : v;
  endfunction

  assign fx_last  = (fx_q == fx_b_q - CNT_W'(1));
  assign fy_last  = (fy_q == fy_b_q - CNT_W'(1));
  assign ox_last  = (ox_q == ox_b_q - CNT_W'(1));
  assign oy_last  = (oy_q == oy_b_q - CNT_W'(1));
  assign all_last = fx_last && fy_last && ox_last && oy_last;
  assign bank_inc = bank_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    in_w_d        = in_w_q;
    ox_b_d        = ox_b_q;
    oy_b_d        = oy_b_q;
    fx_b_d        = fx_b_q;
    fy_b_d        = fy_b_q;
    banks_d       = banks_q;
    stride_d      = stride_q;
    fx_d          = fx_q;
    fy_d          = fy_q;
    ox_d          = ox_q;
    oy_d          = oy_q;
    bank_d        = bank_q;
    config_done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (config_en) begin
          in_w_d        = nz(cfg_in_w);
          ox_b_d        = nz(cfg_ox);
          oy_b_d        = nz(cfg_oy);
          fx_b_d        = nz(cfg_fx);
          fy_b_d        = nz(cfg_fy);
          banks_d       = nz(cfg_num_banks);
          stride_d      = (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
          fx_d          = {CNT_W{1'b0}};
          fy_d          = {CNT_W{1'b0}};
          ox_d          = {CNT_W{1'b0}};
          oy_d          = {CNT_W{1'b0}};
          bank_d        = {CNT_W{1'b0}};
          config_done_d = 1'b1;
          state_d       = WAIT_SWITCH;
        end else begin
          state_d = state_q;
        end
      end
      WAIT_SWITCH: begin
        if (switch) begin
          fx_d    = {CNT_W{1'b0}};
          fy_d    = {CNT_W{1'b0}};
          ox_d    = {CNT_W{1'b0}};
          oy_d    = {CNT_W{1'b0}};
          state_d = READ;
        end else begin
          state_d = WAIT_SWITCH;
        end
      end
      READ: begin
        if (rready) begin
          // Nested carry: fx innermost, oy outermost.
          if (fx_last) begin
            fx_d = {CNT_W{1'b0}};
            if (fy_last) begin
              fy_d = {CNT_W{1'b0}};
              if (ox_last) begin
                ox_d = {CNT_W{1'b0}};
                if (oy_last) begin
                  oy_d = {CNT_W{1'b0}};
                end else begin
                  oy_d = oy_q + CNT_W'(1);
                end
              end else begin
                ox_d = ox_q + CNT_W'(1);
              end
            end else begin
              fy_d = fy_q + CNT_W'(1);
            end
          end else begin
            fx_d = fx_q + CNT_W'(1);
          end
          if (all_last) begin
            bank_d  = bank_inc;
            state_d = (bank_inc == banks_q) ? DONE : WAIT_SWITCH;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_w_q        <= {CNT_W{1'b0}};
      ox_b_q        <= {CNT_W{1'b0}};
      oy_b_q        <= {CNT_W{1'b0}};
      fx_b_q        <= {CNT_W{1'b0}};
      fy_b_q        <= {CNT_W{1'b0}};
      banks_q       <= {CNT_W{1'b0}};
      stride_q      <= 2'd0;
      fx_q          <= {CNT_W{1'b0}};
      fy_q          <= {CNT_W{1'b0}};
      ox_q          <= {CNT_W{1'b0}};
      oy_q          <= {CNT_W{1'b0}};
      bank_q        <= {CNT_W{1'b0}};
      config_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_w_q        <= in_w_d;
      ox_b_q        <= ox_b_d;
      oy_b_q        <= oy_b_d;
      fx_b_q        <= fx_b_d;
      fy_b_q        <= fy_b_d;
      banks_q       <= banks_d;
      stride_q      <= stride_d;
      fx_q          <= fx_d;
      fy_q          <= fy_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      bank_q        <= bank_d;
      config_done_q <= config_done_d;
    end
  end

  assign ren             = (state_q == READ);
  assign ready_to_switch = (state_q == WAIT_SWITCH);
  assign done            = (state_q == DONE);
  assign last_read       = ren && all_last;
  assign config_done     = config_done_q;

  // Arithmetic is carried out at ADDR_W bits so the result wraps modulo the buffer size.
  always_comb begin
    if (state_q == READ) begin
      raddr = (ADDR_W'(oy_q) * ADDR_W'(stride_q) + ADDR_W'(fy_q)) * ADDR_W'(in_w_q)
            + ADDR_W'(ox_q) * ADDR_W'(stride_q) + ADDR_W'(fx_q);
    end else begin
      raddr = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_ifmap_read_ctrl.sv
// Scoreboard bench for ifmap_read_ctrl: expected addresses are queued from a
// loop-nest model when a bank is set up and compared as the DUT issues reads.
module tb_ifmap_read_ctrl;

  logic       clk = 1'b0;
  logic       rst, config_en, switch, rready;
  logic [3:0] cfg_in_w, cfg_ox, cfg_oy, cfg_fx, cfg_fy, cfg_num_banks;
  logic [1:0] cfg_stride;
  logic       config_done, ready_to_switch, ren, last_read, done;
  logic [7:0] raddr;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  ifmap_read_ctrl #(.ADDR_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .config_en(config_en),
    .cfg_in_w(cfg_in_w), .cfg_ox(cfg_ox), .cfg_oy(cfg_oy),
    .cfg_fx(cfg_fx), .cfg_fy(cfg_fy), .cfg_num_banks(cfg_num_banks),
    .cfg_stride(cfg_stride), .config_done(config_done),
    .ready_to_switch(ready_to_switch), .switch(switch), .ren(ren),
    .rready(rready), .raddr(raddr), .last_read(last_read), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Queue one bank's worth of addresses, oy outermost, fx innermost.
  task automatic push_bank(input int w, input int ox, input int oy,
                           input int fx, input int fy, input int s);
    int ew, es;
    ew = nz(w);
    es = nz(s);
    for (int y = 0; y < nz(oy); y++)
      for (int x = 0; x < nz(ox); x++)
        for (int j = 0; j < nz(fy); j++)
          for (int i = 0; i < nz(fx); i++)
            exp_q.push_back(8'(((y * es + j) * ew) + x * es + i));
  endtask

  task automatic do_config(input int w, input int ox, input int oy, input int fx,
                           input int fy, input int nb, input int s, input string tag);
    cfg_in_w = 4'(w); cfg_ox = 4'(ox); cfg_oy = 4'(oy);
    cfg_fx = 4'(fx); cfg_fy = 4'(fy); cfg_num_banks = 4'(nb); cfg_stride = 2'(s);
    config_en = 1'b1;
    @(negedge clk);
    config_en = 1'b0;
    checks++;
    if (config_done !== 1'b1) begin
      failures++; $display("FAIL %s config_done pulse actual=%b expected=1", tag, config_done);
    end
    checks++;
    if (ready_to_switch !== 1'b1 || ren !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL %s wait_switch outs actual rts=%b ren=%b done=%b expected 1,0,0",
                           tag, ready_to_switch, ren, done);
    end
    @(negedge clk);
    checks++;
    if (config_done !== 1'b0) begin
      failures++; $display("FAIL %s config_done width actual=%b expected=0", tag, config_done);
    end
  endtask

  task automatic pulse_switch();
    switch = 1'b1;
    @(negedge clk);
    switch = 1'b0;
  endtask

  // Drain the scoreboard; stall_mode applies the rready pattern 1,0,0,1.
  task automatic run_reads(input int stall_mode, input string tag);
    int cyc;
    logic stalled_prev, exp_last;
    logic [7:0] addr_prev;
    cyc = 0;
    stalled_prev = 1'b0;
    addr_prev = 8'd0;
    while (exp_q.size() != 0 && cyc < 200) begin
      rready = (stall_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      exp_last = (exp_q.size() == 1);
      checks++;
      if (ren !== 1'b1) begin
        failures++; $display("FAIL %s ren cyc=%0d actual=%b expected=1", tag, cyc, ren);
      end
      checks++;
      if (raddr !== exp_q[0]) begin
        failures++; $display("FAIL %s raddr cyc=%0d actual=%0d expected=%0d", tag, cyc, raddr, exp_q[0]);
      end
      checks++;
      if (last_read !== exp_last) begin
        failures++; $display("FAIL %s last_read cyc=%0d actual=%b expected=%b", tag, cyc, last_read, exp_last);
      end
      if (stalled_prev) begin
        checks++;
        if (raddr !== addr_prev) begin
          failures++; $display("FAIL %s stall hold actual=%0d expected=%0d", tag, raddr, addr_prev);
        end
      end
      stalled_prev = !rready;
      addr_prev = raddr;
      if (rready && ren) void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s timeout actual_left=%0d expected_left=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; config_en = 1'b0; switch = 1'b0; rready = 1'b0;
    cfg_in_w = 4'd0; cfg_ox = 4'd0; cfg_oy = 4'd0; cfg_fx = 4'd0; cfg_fy = 4'd0;
    cfg_num_banks = 4'd0; cfg_stride = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({config_done, ready_to_switch, ren, last_read, done, raddr} !== 13'd0) begin
      failures++; $display("FAIL reset outputs actual=%h expected=0",
                           {config_done, ready_to_switch, ren, last_read, done, raddr});
    end
    rst = 1'b0;
    switch = 1'b1;
    @(negedge clk);
    switch = 1'b0;
    @(negedge clk);
    checks++;
    if ({config_done, ready_to_switch, ren, last_read, done, raddr} !== 13'd0) begin
      failures++; $display("FAIL idle_switch outputs actual=%h expected=0",
                           {config_done, ready_to_switch, ren, last_read, done, raddr});
    end
  endtask

  task automatic test_basic();
    do_config(4, 2, 2, 2, 2, 1, 1, "basic");
    push_bank(4, 2, 2, 2, 2, 1);
    pulse_switch();
    run_reads(0, "basic");
    checks++;
    if (done !== 1'b1 || ren !== 1'b0 || ready_to_switch !== 1'b0) begin
      failures++; $display("FAIL basic end actual done=%b ren=%b rts=%b expected 1,0,0",
                           done, ren, ready_to_switch);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL basic done_level actual=%b expected=1", done);
    end
  endtask

  task automatic test_multibank();
    do_config(5, 2, 2, 1, 1, 2, 2, "multibank");
    push_bank(5, 2, 2, 1, 1, 2);
    pulse_switch();
    run_reads(0, "bank1");
    repeat (3) begin
      checks++;
      if (ready_to_switch !== 1'b1 || done !== 1'b0 || ren !== 1'b0) begin
        failures++; $display("FAIL bank_gap actual rts=%b done=%b ren=%b expected 1,0,0",
                             ready_to_switch, done, ren);
      end
      @(negedge clk);
    end
    push_bank(5, 2, 2, 1, 1, 2);
    pulse_switch();
    run_reads(0, "bank2");
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL multibank done actual=%b expected=1", done);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] held;
    do_config(4, 3, 1, 2, 1, 1, 1, "ignored");
    push_bank(4, 3, 1, 2, 1, 1);
    pulse_switch();
    rready = 1'b0;
    held = raddr;
    switch = 1'b1; config_en = 1'b1; cfg_in_w = 4'd7; cfg_stride = 2'd3;
    @(negedge clk);
    switch = 1'b0; config_en = 1'b0;
    checks++;
    if (config_done !== 1'b0 || ren !== 1'b1 || raddr !== held) begin
      failures++; $display("FAIL read_ignore actual cd=%b ren=%b raddr=%0d expected 0,1,%0d",
                           config_done, ren, raddr, held);
    end
    run_reads(0, "ignored");
  endtask

  task automatic test_stall();
    do_config(4, 2, 2, 2, 2, 1, 1, "stall");
    push_bank(4, 2, 2, 2, 2, 1);
    pulse_switch();
    run_reads(1, "stall");
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL stall done actual=%b expected=1", done);
    end
  endtask

  task automatic test_reset_mid();
    do_config(4, 2, 2, 2, 2, 1, 1, "rstmid");
    push_bank(4, 2, 2, 2, 2, 1);
    pulse_switch();
    rready = 1'b1;
    repeat (2) begin
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (raddr !== exp_q[0]) begin
      failures++; $display("FAIL rstmid third_addr actual=%0d expected=%0d", raddr, exp_q[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({config_done, ready_to_switch, ren, last_read, done, raddr} !== 13'd0) begin
      failures++; $display("FAIL rstmid during actual=%h expected=0",
                           {config_done, ready_to_switch, ren, last_read, done, raddr});
    end
    rst = 1'b0; rready = 1'b0;
    @(negedge clk);
    checks++;
    if ({config_done, ready_to_switch, ren, last_read, done, raddr} !== 13'd0) begin
      failures++; $display("FAIL rstmid after actual=%h expected=0",
                           {config_done, ready_to_switch, ren, last_read, done, raddr});
    end
    exp_q.delete();
    do_config(3, 2, 1, 2, 2, 1, 1, "restart");
    push_bank(3, 2, 1, 2, 2, 1);
    pulse_switch();
    run_reads(0, "restart");
  endtask

  task automatic test_zero();
    do_config(0, 0, 0, 0, 0, 0, 0, "zero");
    push_bank(0, 0, 0, 0, 0, 0);
    pulse_switch();
    run_reads(0, "zero");
    checks++;
    if (done !== 1'b1 || ren !== 1'b0) begin
      failures++; $display("FAIL zero end actual done=%b ren=%b expected 1,0", done, ren);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multibank();
    test_ignored();
    test_stall();
    test_reset_mid();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
